// File: rtl/conv_pkg.sv
// Shared widths, width helpers and rescale functions for the K x K streaming convolver.
// CONV_SATURATE_EN selects clamping instead of wrap when the result is narrowed.
package conv_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_COEF_W    = 8;
   localparam int DEF_K         = 3;
   localparam int DEF_FRAC_BITS = 7;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Worst-case sum of K*K full-precision products fits without overflow.
   function automatic int acc_width(input int data_w, input int coef_w, input int k);
      return data_w + coef_w + clog2(k * k);
   endfunction

   // Round half up, then arithmetic shift; no rounding term when frac is 0.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                      input int frac);
      logic signed [63:0] r;
      r = value;
      if (frac > 0) r = value + (64'sd1 <<< (frac - 1));
      return r >>> frac;
   endfunction

   function automatic logic signed [63:0] clamp(input logic signed [63:0] value,
                                                input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registers the K*K window products and sums them for the rescale stage.
// The sum is combinational from the product registers; synthesis balances the chain.
module conv_adder_tree
   import conv_pkg::*;
#(
   parameter int N     = 9,
   parameter int P_W   = 16,
   parameter int ACC_W = 20
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    en,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [N*P_W-1:0]        prods,
   output logic signed [ACC_W-1:0] sum,
   output logic                    sum_valid
);

   logic signed [P_W-1:0] prod_q [N];

   always_ff @(posedge clk) begin
      if (!nrst) begin
         for (int i = 0; i < N; i++) prod_q[i] <= '0;
         sum_valid <= 1'b0;
      end else if (en) begin
         for (int i = 0; i < N; i++) prod_q[i] <= prods[i*P_W +: P_W];
         sum_valid <= in_valid && !flush;
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum = sum + {{(ACC_W-P_W){prod_q[i][P_W-1]}}, prod_q[i]};
      end
   end

endmodule

// File: rtl/conv2d_stream.sv
// K x K streaming 2-D convolver: kernel load, sliding window, product/sum and rescale stages.
// Build option CONV_SATURATE_EN clamps the narrowed result; otherwise it wraps.
module conv2d_stream
   import conv_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int COEF_W    = DEF_COEF_W,
   parameter int K         = DEF_K,
   parameter int FRAC_BITS = DEF_FRAC_BITS
) (
   input  logic                clk,
   input  logic                i_nrst,
   input  logic                i_load_knl,
   input  logic                i_data_valid,
   input  logic                i_stall,
   input  logic [K*DATA_W-1:0] i_data,
   output logic [DATA_W-1:0]   o_pixel,
   output logic                o_valid,
   output logic                o_knl_ready
);

   localparam int P_W   = DATA_W + COEF_W;
   localparam int ACC_W = acc_width(DATA_W, COEF_W, K);
   localparam int N     = K * K;
   localparam int CNT_W = clog2(K + 1);

   logic signed [DATA_W-1:0] win [K][K];
   logic signed [COEF_W-1:0] knl [K][K];
   logic [CNT_W-1:0]         load_cnt;
   logic [CNT_W-1:0]         fill;
   logic                     in_load;
   logic                     win_done;

   logic [CNT_W-1:0]         beat_idx;
   logic                     load_wr;
   logic                     complete;
   logic [N*P_W-1:0]         prods;
   logic signed [P_W-1:0]    a_ext;
   logic signed [P_W-1:0]    b_ext;
   logic signed [ACC_W-1:0]  acc;
   logic                     acc_valid;
   logic signed [63:0]       acc_ext;
   logic signed [63:0]       scaled;
   logic signed [63:0]       narrowed;

   // A load beat after i_load_knl was low restarts the row sequence at beat 0.
   always_comb begin
      beat_idx = in_load ? load_cnt : '0;
      load_wr  = !in_load || (load_cnt < CNT_W'(K));
      complete = o_knl_ready && (fill >= CNT_W'(K - 1));
   end

   always_comb begin
      prods = '0;
      a_ext = '0;
      b_ext = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            a_ext = {{COEF_W{win[r][c][DATA_W-1]}}, win[r][c]};
            b_ext = {{DATA_W{knl[r][c][COEF_W-1]}}, knl[r][c]};
            prods[(r*K+c)*P_W +: P_W] = a_ext * b_ext;
         end
      end
   end

   conv_adder_tree #(
      .N     (N),
      .P_W   (P_W),
      .ACC_W (ACC_W)
   ) u_tree (
      .clk       (clk),
      .nrst      (i_nrst),
      .en        (!i_stall),
      .flush     (i_load_knl),
      .in_valid  (win_done),
      .prods     (prods),
      .sum       (acc),
      .sum_valid (acc_valid)
   );

   always_comb begin
      acc_ext = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
      scaled  = round_shift(acc_ext, FRAC_BITS);
`ifdef CONV_SATURATE_EN
      narrowed = clamp(scaled, DATA_W);
`else
      narrowed = scaled;
`endif
   end

   // Coefficients arrive in the low COEF_W bits of each DATA_W lane (COEF_W <= DATA_W).
   always_ff @(posedge clk) begin
      if (!i_nrst) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win[r][c] <= '0;
               knl[r][c] <= '0;
            end
         end
         load_cnt    <= '0;
         fill        <= '0;
         in_load     <= 1'b0;
         win_done    <= 1'b0;
         o_pixel     <= '0;
         o_valid     <= 1'b0;
         o_knl_ready <= 1'b0;
      end else if (!i_stall) begin
         in_load <= i_load_knl;
         if (i_load_knl) begin
            fill     <= '0;
            win_done <= 1'b0;
            o_valid  <= 1'b0;
            if (load_wr) begin
               for (int r = 0; r < K; r++) begin
                  if (r == K - 1 - int'(beat_idx)) begin
                     for (int l = 0; l < K; l++) begin
                        knl[r][K-1-l] <= i_data[l*DATA_W +: COEF_W];
                     end
                  end
               end
               load_cnt    <= beat_idx + CNT_W'(1);
               o_knl_ready <= (beat_idx == CNT_W'(K - 1));
            end
         end else begin
            // Row 0 holds the newest slice; older rows move down one place.
            if (i_data_valid) begin
               for (int r = K - 1; r > 0; r--) win[r] <= win[r-1];
               for (int l = 0; l < K; l++) win[0][l] <= i_data[l*DATA_W +: DATA_W];
               fill     <= (fill == CNT_W'(K)) ? fill : fill + CNT_W'(1);
               win_done <= complete;
            end else begin
               fill     <= '0;
               win_done <= 1'b0;
            end
            o_valid <= acc_valid;
            if (acc_valid) o_pixel <= narrowed[DATA_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream (K=3, 8-bit, FRAC_BITS=7) with an output scoreboard.
module tb_conv2d_stream;

   localparam logic [23:0] ID_MID = 24'h007F00;

   logic        clk = 1'b0;
   logic        i_nrst = 1'b0;
   logic        i_load_knl = 1'b0;
   logic        i_data_valid = 1'b0;
   logic        i_stall = 1'b0;
   logic [23:0] i_data = '0;
   logic [7:0]  o_pixel;
   logic        o_valid;
   logic        o_knl_ready;

   int          n_total = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  mon_exp;
   logic        prev_stall = 1'b0;

   always #5 clk = ~clk;

   conv2d_stream #(
      .DATA_W    (8),
      .COEF_W    (8),
      .K         (3),
      .FRAC_BITS (7)
   ) dut (
      .clk          (clk),
      .i_nrst       (i_nrst),
      .i_load_knl   (i_load_knl),
      .i_data_valid (i_data_valid),
      .i_stall      (i_stall),
      .i_data       (i_data),
      .o_pixel      (o_pixel),
      .o_valid      (o_valid),
      .o_knl_ready  (o_knl_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [23:0] d);
      i_data_valid = 1'b1;
      i_data = d;
      cyc();
      i_data_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      i_data_valid = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic load(input logic [23:0] b0, input logic [23:0] b1,
                       input logic [23:0] b2, input logic [23:0] b3, input int n);
      i_load_knl = 1'b1;
      for (int i = 0; i < n; i++) begin
         case (i)
            0: i_data = b0;
            1: i_data = b1;
            2: i_data = b2;
            default: i_data = b3;
         endcase
         cyc();
      end
      i_load_knl = 1'b0;
   endtask

   // A new output is one with o_valid high that was produced by an unstalled edge.
   always @(negedge clk) begin
      if (o_valid && !prev_stall) begin
         if (exp_q.size() == 0) begin
            chk("extra_valid", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("pixel", {24'd0, o_pixel}, {24'd0, mon_exp});
         end
      end
      prev_stall = i_stall;
   end

   initial begin
      // reset state
      repeat (2) cyc();
      chk("rst_pixel", {24'd0, o_pixel}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_ready", {31'd0, o_knl_ready}, 32'd0);
      i_nrst = 1'b1;
      idle(1);

      // identity kernel, constant 100 -> 99, latency 2
      load(24'h0, ID_MID, 24'h0, 24'h0, 3);
      chk("id_ready", {31'd0, o_knl_ready}, 32'd1);
      repeat (3) exp_q.push_back(8'd99);
      beat(24'h646464);
      beat(24'h646464);
      beat(24'h646464);
      chk("lat_e0", {31'd0, o_valid}, 32'd0);
      beat(24'h646464);
      chk("lat_e1", {31'd0, o_valid}, 32'd0);
      beat(24'h646464);
      chk("lat_e2_valid", {31'd0, o_valid}, 32'd1);
      chk("lat_e2_pixel", {24'd0, o_pixel}, 32'd99);
      idle(3);
      chk("drain_pos", exp_q.size(), 32'd0);
      chk("hold_pos", {24'd0, o_pixel}, 32'd99);

      // identity kernel, -128 -> -127
      repeat (2) exp_q.push_back(8'h81);
      repeat (4) beat(24'h808080);
      idle(3);
      chk("drain_neg", exp_q.size(), 32'd0);
      chk("hold_neg", {24'd0, o_pixel}, 32'h81);

      // all-127 kernel and pixels; the 4th load beat must be ignored
      load(24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F, 24'h000000, 4);
      chk("ovf_ready", {31'd0, o_knl_ready}, 32'd1);
`ifdef CONV_SATURATE_EN
      exp_q.push_back(8'd127);
`else
      exp_q.push_back(8'd110);
`endif
      repeat (3) beat(24'h7F7F7F);
      idle(3);
      chk("drain_ovf", exp_q.size(), 32'd0);

      // stall for 3 cycles after the 5th beat
      load(24'h0, ID_MID, 24'h0, 24'h0, 3);
      exp_q.push_back(8'd50);
      exp_q.push_back(8'hCE);
      exp_q.push_back(8'h7E);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'hFF);
      beat(24'h110A22);
      beat(24'h113222);
      beat(24'h11CE22);
      beat(24'h117F22);
      beat(24'h110122);
      i_stall = 1'b1;
      i_data_valid = 1'b1;
      i_data = 24'h11FF22;
      repeat (3) cyc();
      i_stall = 1'b0;
      beat(24'h11FF22);
      beat(24'h110022);
      idle(3);
      chk("drain_stall", exp_q.size(), 32'd0);

      // valid gap after 4 beats
      exp_q.push_back(8'd30);
      exp_q.push_back(8'd40);
      exp_q.push_back(8'd79);
      beat(24'h111422);
      beat(24'h111E22);
      beat(24'h112822);
      beat(24'h113C22);
      idle(1);
      beat(24'h114622);
      beat(24'h115022);
      chk("gap_n2", {31'd0, o_valid}, 32'd0);
      beat(24'h115A22);
      chk("gap_n3", {31'd0, o_valid}, 32'd0);
      idle(1);
      chk("gap_i1", {31'd0, o_valid}, 32'd0);
      idle(1);
      chk("gap_i2_valid", {31'd0, o_valid}, 32'd1);
      chk("gap_i2_pixel", {24'd0, o_pixel}, 32'd79);
      idle(2);
      chk("drain_gap", exp_q.size(), 32'd0);

      // partial load: no kernel, no output
      load(24'h0, ID_MID, 24'h0, 24'h0, 2);
      chk("part_ready", {31'd0, o_knl_ready}, 32'd0);
      repeat (4) beat(24'h646464);
      idle(2);
      chk("part_none", {31'd0, o_valid}, 32'd0);

      // full reload, then reset mid-stream drops in-flight results
      load(24'h0, ID_MID, 24'h0, 24'h0, 3);
      chk("full_ready", {31'd0, o_knl_ready}, 32'd1);
      exp_q.push_back(8'd99);
      repeat (5) beat(24'h646464);
      chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
      i_nrst = 1'b0;
      i_data_valid = 1'b1;
      i_data = 24'h646464;
      cyc();
      chk("mid_rst_pixel", {24'd0, o_pixel}, 32'd0);
      chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, o_knl_ready}, 32'd0);
      i_nrst = 1'b1;
      repeat (3) beat(24'h646464);
      idle(3);
      chk("post_rst_none", {31'd0, o_valid}, 32'd0);
      chk("drain_rst", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
